pep_gram_arb: RTL and testbench
===============================

Name: pep_gram_arb

Overview:
- Per-bank access arbiter for the GLWE RAM (GRAM), which has GRAM_NB banks.
- It shares the banks between the four PE-PBS access actors: LDG write (actor 0), MMACC feed read (actor 1), MMACC acc write (actor 2) and SXT read (actor 3).
- It issues single-beat grants. The acc write actor has absolute priority. The other actors are served round-robin per bank, with burst locking and starvation escalation.
- It sits between the actors and the GRAM bank muxes inside pe_pbs.

Parameters:
- ACTOR_NB, 4, number of requesters. Fixed: actor index 2 is the non-stallable acc writer.
- STARVE_TH, 16, wait cycles after which a waiting actor is escalated.
- WAIT_W, 8, width of the per-actor wait counter (saturating).

Ports:
- clk  in  1  clock
- s_rst_n  in  1  reset, asynchronous, active-low
- acs_req  in  ACTOR_NB  per-actor request; held until granted
- acs_bank  in  ACTOR_NB*GRAM_ID_W  target bank per actor; stable while req=1
- acs_last  in  ACTOR_NB  current beat ends the actor's burst
- acs_gnt  out  ACTOR_NB  grant, one beat, same cycle as req
- bank_sel  out  GRAM_NB*ACTOR_W  granted actor per bank (ACTOR_W = clog2(ACTOR_NB))
- bank_vld  out  GRAM_NB  bank has a grant this cycle
- starve_err  out  1  registered pulse; a wait counter reached saturation
- acc_err  out  1  registered pulse; acc request not granted (must never fire)

Behaviour:
- Grant path: combinational from acs_req, acs_bank and registered state. Zero latency.
- Handshake: a beat completes when req&gnt. The actor may change bank or drop req only after gnt. Req is not allowed to fall without gnt.
- Per-bank priority order:
  1. Actor 2 (acc write). It always wins its bank.
  2. Lock owner of the bank, if a lock is held.
  3. Escalated actors, those with wait_cnt >= STARVE_TH, lowest index first.
  4. Round-robin among the rest, starting from rr_ptr[bank].
- At most one grant per bank per cycle. An actor receives at most one grant per cycle.
- Lock state per bank: {lock_vld, lock_owner}.
  - Set when an actor 0/1/3 gets a grant with acs_last=0.
  - Cleared on that owner's granted beat with acs_last=1.
  - While locked, no other non-acc actor is granted on the bank.
  - An acc grant pauses the burst: owner gnt=0 that cycle, lock retained.
  - Actor 2 never sets a lock; its acs_last is ignored.
- rr_ptr[bank]: after a round-robin grant to actor a, becomes (a+1) mod ACTOR_NB, skipping 2. Unchanged on acc, lock-owner or escalated grants.
- Wait counter per actor 0/1/3:
  - Increments, saturating at 2^WAIT_W-1, each cycle req=1 and gnt=0.
  - Cleared on gnt, and also when req=0.
- starve_err: 1-cycle pulse, one cycle after any counter transitions to saturation.
- acc_err: 1-cycle pulse one cycle after acs_req[2]=1 & acs_gnt[2]=0. Required to remain 0.
- Simultaneous last and new request: a lock released on cycle t is re-arbitrated on cycle t+1. No same-cycle handover.
- Reset:
  - Asynchronous assertion: locks, rr_ptr (to 0), wait counters and error pulses are cleared immediately.
  - acs_gnt/bank_vld are 0 while reset is asserted, regardless of req.
  - Reset in mid-burst drops the lock; the actor restarts its burst.
- Reset values: acs_gnt=0, bank_sel=0, bank_vld=0, starve_err=0, acc_err=0.

Optional Feature:
- Macro: PEP_GRAM_ARB_STAT_EN.
- When defined, adds output gnt_cnt (ACTOR_NB*32) and input stat_clr. These are 32-bit wrapping per-actor granted-beat counters, synchronously cleared by stat_clr, with stat_clr winning over a same-cycle increment.
- When undefined, these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Add to pep_common_param_pkg:
  - ACTOR_W.
  - Actor index constants GRAM_ACTOR_LDG=0, GRAM_ACTOR_FEED=1, GRAM_ACTOR_ACC=2, GRAM_ACTOR_SXT=3.
  - typedef gram_lock_t {vld, owner[ACTOR_W]}.
  - typedef pep_gram_arb_error_t {starve, acc}, to be appended to pep_mmacc_error_t later.
- One sub-module: pep_gram_arb_bank.
  - Handles a single bank's lock, rr_ptr and priority select.
  - Instantiated GRAM_NB times.
  - The top level resolves per-actor grants and owns the wait counters and errors.

Test Plan:
- Actors 0,1,3 all request bank 1 continuously, last=1, no acc. Required: grants rotate 0,1,3,0,1,3; rr_ptr[1] ends at 0 after 3 grants.
- Actor 3 bursts 4 beats on bank 2 (last on beat 4); actor 0 requests bank 2 from cycle 1. Required: actor 0 is granted only on the cycle after actor 3's last beat.
- During actor 3's locked burst on bank 0, actor 2 requests bank 0 for 2 cycles. Required: actor 3 gnt=0 for those 2 cycles, actor 2 granted both, burst resumes, acc_err stays 0.
- Actor 2 holds bank 3 continuously; actor 1 waits on bank 3. Required: wait_cnt[1] reaches STARVE_TH=16 (escalated but still blocked) and saturates at 255. starve_err pulses once, at cycle 256 of waiting.
- All four actors target different banks simultaneously. Required: all four gnt=1 in the same cycle, with bank_sel matching per bank.
- Assert s_rst_n low mid-burst, then release. Required: gnt=0 immediately; after release the lock is cleared, rr_ptr=0 and the first grant follows priority from reset.

Source files
------------

// File: rtl/pep_gram_arb_pkg.sv
// pep_gram_arb_pkg: shared constants, types and the round-robin step helper for the GRAM arbiter
package pep_gram_arb_pkg;
  localparam int ACTOR_NB  = 4;
  localparam int GRAM_NB   = 4;
  localparam int GRAM_ID_W = $clog2(GRAM_NB);
  localparam int ACTOR_W   = $clog2(ACTOR_NB);
  localparam int STARVE_TH = 16;
  localparam int WAIT_W    = 8;
  localparam logic [ACTOR_W-1:0] GRAM_ACTOR_LDG  = 2'd0;
  localparam logic [ACTOR_W-1:0] GRAM_ACTOR_FEED = 2'd1;
  localparam logic [ACTOR_W-1:0] GRAM_ACTOR_ACC  = 2'd2;
  localparam logic [ACTOR_W-1:0] GRAM_ACTOR_SXT  = 2'd3;
  typedef struct packed {
    logic               vld;
    logic [ACTOR_W-1:0] owner;
  } gram_lock_t;
  typedef struct packed {
    logic starve;
    logic acc;
  } pep_gram_arb_error_t;
  // next round-robin start after a grant to a; the acc writer never takes part in rr
  function automatic logic [ACTOR_W-1:0] rr_next(input logic [ACTOR_W-1:0] a);
    logic [ACTOR_W-1:0] n;
    n = a + 1'b1;
    return n == GRAM_ACTOR_ACC ? n + 1'b1 : n;
  endfunction
endpackage

// File: rtl/pep_gram_arb_if.sv
// pep_gram_arb_if: actor-side request/grant bundle (req, bank, last in; gnt out of the arbiter)
interface pep_gram_arb_if;
  import pep_gram_arb_pkg::*;
  logic [ACTOR_NB-1:0]           acs_req;
  logic [ACTOR_NB*GRAM_ID_W-1:0] acs_bank;
  logic [ACTOR_NB-1:0]           acs_last;
  logic [ACTOR_NB-1:0]           acs_gnt;
  modport master (output acs_req, acs_bank, acs_last, input acs_gnt);
  modport slave  (input acs_req, acs_bank, acs_last, output acs_gnt);
endinterface

// File: rtl/pep_gram_arb_bank.sv
// pep_gram_arb_bank: one GRAM bank's lock, rr pointer and priority select
//   req  : actors requesting this bank       last : per-actor burst end
//   esc  : per-actor escalation (starving)   vld/sel : grant and granted actor
module pep_gram_arb_bank
  import pep_gram_arb_pkg::*;
(
  input  logic                clk,
  input  logic                s_rst_n,
  input  logic [ACTOR_NB-1:0] req,
  input  logic [ACTOR_NB-1:0] last,
  input  logic [ACTOR_NB-1:0] esc,
  output logic                vld,
  output logic [ACTOR_W-1:0]  sel
);
  gram_lock_t         lock;
  logic [ACTOR_W-1:0] rr_ptr, esc_sel, rr_sel, idx;
  logic               esc_vld, rr_vld, acc, rr_win;
  // both scans run downward so the lowest index / nearest rr offset is written last and wins
  always_comb begin
    esc_vld = 1'b0;
    esc_sel = '0;
    rr_vld  = 1'b0;
    rr_sel  = '0;
    idx     = '0;
    for (int i = ACTOR_NB - 1; i >= 0; i--)
      if (ACTOR_W'(i) != GRAM_ACTOR_ACC && req[i] && esc[i]) begin
        esc_vld = 1'b1;
        esc_sel = ACTOR_W'(i);
      end
    for (int i = ACTOR_NB - 1; i >= 0; i--) begin
      idx = rr_ptr + ACTOR_W'(i);
      if (idx != GRAM_ACTOR_ACC && req[idx]) begin
        rr_vld = 1'b1;
        rr_sel = idx;
      end
    end
    acc    = req[GRAM_ACTOR_ACC];
    vld    = acc | (lock.vld ? req[lock.owner] : (esc_vld | rr_vld));
    sel    = acc ? GRAM_ACTOR_ACC : lock.vld ? lock.owner : esc_vld ? esc_sel : rr_sel;
    rr_win = !acc && !lock.vld && !esc_vld && rr_vld;
  end
  // an acc grant leaves the lock untouched, which is what pauses a burst
  always_ff @(posedge clk or negedge s_rst_n)
    if (!s_rst_n) begin
      lock   <= '0;
      rr_ptr <= '0;
    end else begin
      if (vld && sel != GRAM_ACTOR_ACC) lock <= '{vld: !last[sel], owner: sel};
      if (rr_win) rr_ptr <= rr_next(rr_sel);
    end
endmodule

// File: rtl/pep_gram_arb.sv
// pep_gram_arb: per-bank GRAM access arbiter for the four PE-PBS actors (acc write has absolute priority)
//   acs        : actor req/bank/last in, single-beat gnt out (same cycle)
//   bank_sel   : granted actor per bank      bank_vld : bank granted this cycle
//   starve_err : pulse when a wait counter saturates   acc_err : pulse when acc was refused
//   PEP_GRAM_ARB_STAT_EN adds stat_clr in and gnt_cnt out (32-bit per-actor grant counters)
module pep_gram_arb
  import pep_gram_arb_pkg::*;
#(
  parameter int STARVE_TH_P = STARVE_TH,
  parameter int WAIT_W_P    = WAIT_W
)(
  input  logic                       clk,
  input  logic                       s_rst_n,
  pep_gram_arb_if.slave              acs,
  output logic [GRAM_NB*ACTOR_W-1:0] bank_sel,
  output logic [GRAM_NB-1:0]         bank_vld,
  output logic                       starve_err,
  output logic                       acc_err
`ifdef PEP_GRAM_ARB_STAT_EN
  ,
  input  logic                       stat_clr,
  output logic [ACTOR_NB*32-1:0]     gnt_cnt
`endif
);
  logic [GRAM_NB-1:0][ACTOR_NB-1:0] b_req;
  logic [GRAM_NB-1:0]               b_vld;
  logic [GRAM_NB-1:0][ACTOR_W-1:0]  b_sel;
  logic [ACTOR_NB-1:0]              esc, gnt, sat_hit;
  logic [ACTOR_NB-1:0][WAIT_W_P-1:0] wait_cnt;
  logic [GRAM_ID_W-1:0]             bk;
  always_comb begin
    bk = '0;
    for (int b = 0; b < GRAM_NB; b++)
      for (int a = 0; a < ACTOR_NB; a++)
        b_req[b][a] = acs.acs_req[a] && acs.acs_bank[a*GRAM_ID_W +: GRAM_ID_W] == GRAM_ID_W'(b);
    for (int a = 0; a < ACTOR_NB; a++) begin
      bk         = acs.acs_bank[a*GRAM_ID_W +: GRAM_ID_W];
      esc[a]     = wait_cnt[a] >= WAIT_W_P'(STARVE_TH_P);
      gnt[a]     = s_rst_n && b_vld[bk] && b_sel[bk] == ACTOR_W'(a) && b_req[bk][a];
      sat_hit[a] = acs.acs_req[a] && !gnt[a] && wait_cnt[a] == {{(WAIT_W_P-1){1'b1}}, 1'b0};
    end
    for (int b = 0; b < GRAM_NB; b++) begin
      bank_vld[b]                     = s_rst_n && b_vld[b];
      bank_sel[b*ACTOR_W +: ACTOR_W]  = bank_vld[b] ? b_sel[b] : '0;
    end
  end
  assign acs.acs_gnt = gnt;
  for (genvar g = 0; g < GRAM_NB; g++) begin : g_bank
    pep_gram_arb_bank u_bank (
      .clk     (clk),
      .s_rst_n (s_rst_n),
      .req     (b_req[g]),
      .last    (acs.acs_last),
      .esc     (esc),
      .vld     (b_vld[g]),
      .sel     (b_sel[g])
    );
  end
  // acc's counter is held at zero so it can neither escalate nor raise starve_err
  always_ff @(posedge clk or negedge s_rst_n)
    if (!s_rst_n) begin
      wait_cnt   <= '0;
      starve_err <= 1'b0;
      acc_err    <= 1'b0;
    end else begin
      for (int a = 0; a < ACTOR_NB; a++)
        wait_cnt[a] <= (ACTOR_W'(a) == GRAM_ACTOR_ACC || !acs.acs_req[a] || gnt[a]) ? '0 :
                       (&wait_cnt[a]) ? wait_cnt[a] : wait_cnt[a] + 1'b1;
      starve_err <= |(sat_hit & ~(ACTOR_NB'(1) << GRAM_ACTOR_ACC));
      acc_err    <= acs.acs_req[GRAM_ACTOR_ACC] && !gnt[GRAM_ACTOR_ACC];
    end
`ifdef PEP_GRAM_ARB_STAT_EN
  always_ff @(posedge clk or negedge s_rst_n)
    if (!s_rst_n) gnt_cnt <= '0;
    else
      for (int a = 0; a < ACTOR_NB; a++)
        gnt_cnt[a*32 +: 32] <= stat_clr ? '0 : gnt_cnt[a*32 +: 32] + 32'(gnt[a]);
`endif
endmodule

// File: tb/tb_pep_gram_arb.sv
// tb_pep_gram_arb: directed scoreboard bench for pep_gram_arb
module tb_pep_gram_arb;
  import pep_gram_arb_pkg::*;
  typedef struct packed {
    logic [3:0] gnt;
    logic [3:0] vld;
    logic [7:0] sel;
    logic       starve;
    logic       acc;
  } exp_t;
  logic clk = 1'b0;
  logic s_rst_n = 1'b1;
  logic [7:0] bank_sel;
  logic [3:0] bank_vld;
  logic starve_err, acc_err;
  always #5 clk = ~clk;
  pep_gram_arb_if acs();
`ifdef PEP_GRAM_ARB_STAT_EN
  logic stat_clr = 1'b0;
  logic [ACTOR_NB*32-1:0] gnt_cnt;
`endif
  pep_gram_arb dut (
    .clk        (clk),
    .s_rst_n    (s_rst_n),
    .acs        (acs.slave),
    .bank_sel   (bank_sel),
    .bank_vld   (bank_vld),
    .starve_err (starve_err),
    .acc_err    (acc_err)
`ifdef PEP_GRAM_ARB_STAT_EN
    ,
    .stat_clr   (stat_clr),
    .gnt_cnt    (gnt_cnt)
`endif
  );
  exp_t  q[$];
  int    tq[$];
  int    n_chk = 0;
  int    n_fail = 0;
  exp_t  e, got;
  int    t;
  string tname[7] = '{"reset", "rr_rotate", "lock_burst", "acc_pause", "all_banks", "starve", "rst_burst"};
  // drive one cycle of stimulus and queue the response expected in that same cycle
  // rst_act: 0 none, 1 assert reset mid-cycle, 2 release reset mid-cycle
  task automatic step(input int tst, input logic [3:0] req, input logic [7:0] bank, input logic [3:0] last,
                      input logic [3:0] x_gnt, input logic [3:0] x_vld, input logic [7:0] x_sel,
                      input logic x_starve, input int rst_act);
    exp_t x;
    @(posedge clk);
    #1;
    acs.acs_req  = req;
    acs.acs_bank = bank;
    acs.acs_last = last;
    x = '{x_gnt, x_vld, x_sel, x_starve, 1'b0};
    q.push_back(x);
    tq.push_back(tst);
    if (rst_act == 1) begin
      #1 s_rst_n = 1'b0;
    end else if (rst_act == 2) begin
      #1 s_rst_n = 1'b1;
    end
  endtask
  task automatic idle(input int tst);
    step(tst, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 0);
  endtask
  initial forever begin
    @(negedge clk);
    if (q.size() > 0) begin
      e   = q.pop_front();
      t   = tq.pop_front();
      got = '{acs.acs_gnt, bank_vld, bank_sel, starve_err, acc_err};
      n_chk++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s @%0t: got gnt=%b vld=%b sel=%h starve=%b acc_err=%b, want gnt=%b vld=%b sel=%h starve=%b acc_err=%b",
                 tname[t], $time, got.gnt, got.vld, got.sel, got.starve, got.acc,
                 e.gnt, e.vld, e.sel, e.starve, e.acc);
      end
    end
  end
  initial begin
    acs.acs_req  = '0;
    acs.acs_bank = '0;
    acs.acs_last = '0;
    #2 s_rst_n = 1'b0;
    step(0, 4'hF, 8'hE4, 4'hF, 4'h0, 4'h0, 8'h00, 1'b0, 0);
    step(0, 4'hF, 8'hE4, 4'hF, 4'h0, 4'h0, 8'h00, 1'b0, 0);
    step(0, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 2);
    repeat (2) begin
      step(1, 4'b1011, 8'h55, 4'hF, 4'b0001, 4'b0010, 8'h00, 1'b0, 0);
      step(1, 4'b1011, 8'h55, 4'hF, 4'b0010, 4'b0010, 8'h04, 1'b0, 0);
      step(1, 4'b1011, 8'h55, 4'hF, 4'b1000, 4'b0010, 8'h0C, 1'b0, 0);
    end
    idle(1);
    step(2, 4'b1000, 8'h82, 4'b0000, 4'b1000, 4'b0100, 8'h30, 1'b0, 0);
    step(2, 4'b1001, 8'h82, 4'b0000, 4'b1000, 4'b0100, 8'h30, 1'b0, 0);
    step(2, 4'b1001, 8'h82, 4'b0000, 4'b1000, 4'b0100, 8'h30, 1'b0, 0);
    step(2, 4'b1001, 8'h82, 4'b1001, 4'b1000, 4'b0100, 8'h30, 1'b0, 0);
    step(2, 4'b0001, 8'h82, 4'b1001, 4'b0001, 4'b0100, 8'h00, 1'b0, 0);
    idle(2);
    step(3, 4'b1000, 8'h00, 4'b0000, 4'b1000, 4'b0001, 8'h03, 1'b0, 0);
    step(3, 4'b1100, 8'h00, 4'b0000, 4'b0100, 4'b0001, 8'h02, 1'b0, 0);
    step(3, 4'b1100, 8'h00, 4'b0000, 4'b0100, 4'b0001, 8'h02, 1'b0, 0);
    step(3, 4'b1000, 8'h00, 4'b0000, 4'b1000, 4'b0001, 8'h03, 1'b0, 0);
    step(3, 4'b1000, 8'h00, 4'b1000, 4'b1000, 4'b0001, 8'h03, 1'b0, 0);
    idle(3);
    step(4, 4'hF, 8'hE4, 4'hF, 4'hF, 4'hF, 8'hE4, 1'b0, 0);
    step(4, 4'hF, 8'h39, 4'hF, 4'hF, 4'hF, 8'h93, 1'b0, 0);
    idle(4);
    for (int k = 1; k <= 260; k++)
      step(5, 4'b0110, 8'h3C, 4'hF, 4'b0100, 4'b1000, 8'h80, k == 256, 0);
    step(5, 4'b0010, 8'h3C, 4'hF, 4'b0010, 4'b1000, 8'h40, 1'b0, 0);
    idle(5);
    step(6, 4'b0010, 8'h04, 4'hF, 4'b0010, 4'b0010, 8'h04, 1'b0, 0);
    step(6, 4'b0001, 8'h01, 4'h0, 4'b0001, 4'b0010, 8'h00, 1'b0, 0);
    step(6, 4'b0001, 8'h01, 4'h0, 4'b0001, 4'b0010, 8'h00, 1'b0, 0);
    step(6, 4'b0001, 8'h01, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1);
    step(6, 4'b0001, 8'h01, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 0);
    step(6, 4'h0, 8'h00, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 2);
    step(6, 4'b1011, 8'h86, 4'hF, 4'b0011, 4'b0110, 8'h04, 1'b0, 0);
    idle(6);
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected responses left unchecked, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
